// File: rtl/clk_div_sel_if.sv
// Control and status bundle for the multi-rate divider: rate select, run/step
// inputs, and the tick / square-wave / debug outputs.
interface clk_div_sel_if #(
   parameter int CNT_W = 27
);
   logic [1:0]       sel;
   logic             en;
   logic             step;
   logic             tick;
   logic             clk_out;
   logic [1:0]       sel_active;
   logic [CNT_W-1:0] cnt_out;

   modport master (
      output sel, en, step,
      input  tick, clk_out, sel_active, cnt_out
   );

   modport slave (
      input  sel, en, step,
      output tick, clk_out, sel_active, cnt_out
   );
endinterface

// File: rtl/clk_div_sel.sv
// Multi-rate clock-enable divider with glitch-free rate switching at period
// boundaries, plus pause (en=0) and level-sensitive single-step control.
module clk_div_sel #(
   parameter int          CNT_W = 27,
   parameter int unsigned DIV0  = 100000000,
   parameter int unsigned DIV1  = 2000000,
   parameter int unsigned DIV2  = 200,
   parameter int unsigned DIV3  = 1
) (
   input  logic          clk,
   input  logic          rst,
   clk_div_sel_if.slave  bus
);

   localparam logic [CNT_W:0] DIV0_W = (CNT_W+1)'(DIV0);
   localparam logic [CNT_W:0] DIV1_W = (CNT_W+1)'(DIV1);
   localparam logic [CNT_W:0] DIV2_W = (CNT_W+1)'(DIV2);
   localparam logic [CNT_W:0] DIV3_W = (CNT_W+1)'(DIV3);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             clk_out_q, clk_out_d;
   logic [1:0]       sel_active_q, sel_active_d;

   logic [CNT_W:0]   period;
   logic [CNT_W:0]   last_cnt;
   logic [CNT_W:0]   half;
   logic             adv;

   always_comb begin
      period = DIV3_W;
      case (sel_active_q)
         2'b11:   period = DIV0_W;
         2'b10:   period = DIV1_W;
         2'b01:   period = DIV2_W;
         default: period = DIV3_W;
      endcase
   end

   // Extra bit keeps (P+1)>>1 from wrapping when P is near 2^CNT_W.
   assign last_cnt = period - (CNT_W+1)'(1);
   assign half     = (period + (CNT_W+1)'(1)) >> 1;
   assign adv      = bus.en | bus.step;

   always_comb begin
      cnt_d        = cnt_q;
      tick_d       = 1'b0;
      clk_out_d    = clk_out_q;
      sel_active_d = sel_active_q;
      if (adv) begin
         if ({1'b0, cnt_q} == last_cnt) begin
            cnt_d        = '0;
            tick_d       = 1'b1;
            sel_active_d = bus.sel;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         // At a boundary cnt_d is 0, so the new ratio's HALF is irrelevant.
         clk_out_d = ({1'b0, cnt_d} < half);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         tick_q       <= 1'b0;
         clk_out_q    <= 1'b1;
         sel_active_q <= bus.sel;
      end else begin
         cnt_q        <= cnt_d;
         tick_q       <= tick_d;
         clk_out_q    <= clk_out_d;
         sel_active_q <= sel_active_d;
      end
   end

   assign bus.tick       = tick_q;
   assign bus.clk_out    = clk_out_q;
   assign bus.sel_active = sel_active_q;
   assign bus.cnt_out    = cnt_q;

endmodule

// File: tb/tb_clk_div_sel.sv
// Bench for clk_div_sel: directed scenarios plus randomized run, all outputs
// compared each cycle against an integer reference model of the divider.
module tb_clk_div_sel;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   clk_div_sel_if #(.CNT_W(CNT_W)) bus ();

   clk_div_sel #(
      .CNT_W(CNT_W), .DIV0(10), .DIV1(4), .DIV2(3), .DIV3(1)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Period per select code: 00->1, 01->3, 10->4, 11->10
   int div_tab [4] = '{1, 3, 4, 10};
   int m_cnt  = 0;
   int m_sa   = 0;
   int m_tick = 0;
   int m_clko = 1;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   // One clock: update the model from the inputs seen at the edge, then
   // compare every output midway through the cycle.
   task automatic cycle();
      int p;
      @(posedge clk);
      p = div_tab[m_sa];
      if (rst) begin
         m_cnt  = 0;
         m_tick = 0;
         m_clko = 1;
         m_sa   = int'(bus.sel);
      end else if (bus.en || bus.step) begin
         if (m_cnt == p - 1) begin
            m_cnt  = 0;
            m_tick = 1;
            m_sa   = int'(bus.sel);
         end else begin
            m_cnt  = m_cnt + 1;
            m_tick = 0;
         end
         m_clko = (m_cnt < (p + 1) / 2) ? 1 : 0;
      end else begin
         m_tick = 0;
      end
      @(negedge clk);
      chk("tick",       int'(bus.tick),       m_tick);
      chk("clk_out",    int'(bus.clk_out),    m_clko);
      chk("sel_active", int'(bus.sel_active), m_sa);
      chk("cnt_out",    int'(bus.cnt_out),    m_cnt);
   endtask

   task automatic run_until(input int sa, input int c, input int max_cyc);
      int n = 0;
      while (!(m_sa == sa && m_cnt == c) && n < max_cyc) begin
         cycle();
         n++;
      end
      if (!(m_sa == sa && m_cnt == c)) chk("run_until_timeout", 0, 1);
   endtask

   initial begin
      int n;
      bus.sel  = 2'b10;
      bus.en   = 1'b0;
      bus.step = 1'b0;
      @(negedge clk);

      // 1. reset then run at period 4
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      chk("rst_cnt",  int'(bus.cnt_out),    0);
      chk("rst_tick", int'(bus.tick),       0);
      chk("rst_clko", int'(bus.clk_out),    1);
      chk("rst_sa",   int'(bus.sel_active), 2);
      bus.en = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         cycle();
         chk("t1_tick", int'(bus.tick),    (k % 4 == 0) ? 1 : 0);
         chk("t1_cnt",  int'(bus.cnt_out), k % 4);
         chk("t1_clko", int'(bus.clk_out), ((k % 4) < 2) ? 1 : 0);
      end

      // 2. odd period 3
      bus.sel = 2'b01;
      run_until(1, 0, 20);
      chk("t2_sa", int'(bus.sel_active), 1);
      for (int k = 1; k <= 6; k++) begin
         cycle();
         chk("t2_tick", int'(bus.tick),    (k % 3 == 0) ? 1 : 0);
         chk("t2_clko", int'(bus.clk_out), ((k % 3) < 2) ? 1 : 0);
      end

      // 3. switch 11 -> 10 mid-period
      bus.sel = 2'b11;
      run_until(3, 3, 40);
      bus.sel = 2'b10;
      n = 0;
      do begin
         cycle();
         n++;
         if (!bus.tick) chk("t3_sa_hold", int'(bus.sel_active), 3);
      end while (!bus.tick && n < 20);
      chk("t3_len", n, 7);
      chk("t3_sa",  int'(bus.sel_active), 2);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!bus.tick && n < 20);
      chk("t3_next", n, 4);

      // 4. pause and single step
      run_until(2, 1, 20);
      bus.en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("t4_hold_cnt",  int'(bus.cnt_out), 1);
         chk("t4_hold_tick", int'(bus.tick),    0);
      end
      for (int k = 0; k < 3; k++) begin
         bus.step = 1'b1;
         cycle();
         bus.step = 1'b0;
         chk("t4_step_cnt",  int'(bus.cnt_out), (k == 2) ? 0 : k + 2);
         chk("t4_step_tick", int'(bus.tick),    (k == 2) ? 1 : 0);
         cycle();
      end

      // 5. degenerate period 1, then reset mid-period
      bus.en  = 1'b1;
      bus.sel = 2'b00;
      run_until(0, 0, 20);
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("t5_tick", int'(bus.tick),    1);
         chk("t5_clko", int'(bus.clk_out), 1);
      end
      bus.sel = 2'b11;
      run_until(3, 6, 20);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("t5_rst_cnt",  int'(bus.cnt_out),    0);
      chk("t5_rst_tick", int'(bus.tick),       0);
      chk("t5_rst_clko", int'(bus.clk_out),    1);
      chk("t5_rst_sa",   int'(bus.sel_active), 3);

      // randomized run against the model
      for (int k = 0; k < 600; k++) begin
         rst = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 7) == 0) bus.sel = 2'($urandom_range(0, 3));
         bus.en   = ($urandom_range(0, 3) != 0);
         bus.step = 1'($urandom_range(0, 1));
         cycle();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
